// File: rtl/cpu_datapath_if.sv
// Control-unit-facing strobe/data bundle for cpu_datapath.
// The optional ADD request exists only when ALU_ADD_EN is defined.
interface cpu_datapath_if;
    logic        PCout, Zlowout, MDRout, R3out, R7out;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin, R3in, R4in, R7in;
    logic        IncPC, AND, Read;
    logic [31:0] Mdatain;
    logic [31:0] encoder_input;
    logic [4:0]  operation;
`ifdef ALU_ADD_EN
    logic        ADD;
`endif

    modport master (
`ifdef ALU_ADD_EN
        output ADD,
`endif
        output PCout, Zlowout, MDRout, R3out, R7out,
        output MARin, Zin, PCin, MDRin, IRin, Yin, R3in, R4in, R7in,
        output IncPC, AND, Read, Mdatain, encoder_input,
        input  operation
    );

    modport slave (
`ifdef ALU_ADD_EN
        input  ADD,
`endif
        input  PCout, Zlowout, MDRout, R3out, R7out,
        input  MARin, Zin, PCin, MDRin, IRin, Yin, R3in, R4in, R7in,
        input  IncPC, AND, Read, Mdatain, encoder_input,
        output operation
    );
endinterface

// File: rtl/cpu_datapath.sv
// Single-bus CPU datapath slice: priority-encoded bus, register file subset, Y/Z ALU path.
// Optional macro ALU_ADD_EN adds the Y + bus operation (AND > ADD > IncPC > pass).
module cpu_datapath #(
    parameter int WIDTH = 32
) (
    input  logic           Clock,
    input  logic           Resetn,
    cpu_datapath_if.slave  ctrl
);

    typedef enum logic [4:0] {
        SRC_R3   = 5'd3,
        SRC_R7   = 5'd7,
        SRC_ZHI  = 5'd18,
        SRC_ZLO  = 5'd19,
        SRC_PC   = 5'd20,
        SRC_MDR  = 5'd21
    } bus_src_e;

    typedef enum logic [4:0] {
        OP_PASS = 5'b00000,
        OP_ADD  = 5'b00011,
        OP_AND  = 5'b00101,
        OP_INC  = 5'b11001
    } alu_op_e;

    logic [WIDTH-1:0]   r3, r4, r7, pc, ir, mar, mdr, y;
    logic [2*WIDTH-1:0] z;
    logic [WIDTH-1:0]   bus;
    logic [31:0]        req;
    logic [4:0]         sel;
    logic [2*WIDTH-1:0] alu_c;
    alu_op_e            op;

    always_comb begin
        req     = ctrl.encoder_input;
        req[3]  = req[3]  | ctrl.R3out;
        req[7]  = req[7]  | ctrl.R7out;
        req[19] = req[19] | ctrl.Zlowout;
        req[20] = req[20] | ctrl.PCout;
        req[21] = req[21] | ctrl.MDRout;
    end

    // Ascending scan so the highest set request bit is the last to assign.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (req[i]) sel = 5'(i);
        end
    end

    // An empty request encodes to 0 (R0), which is unimplemented and reads as 0.
    always_comb begin
        bus = '0;
        case (sel)
            SRC_R3:  bus = r3;
            SRC_R7:  bus = r7;
            SRC_ZHI: bus = z[2*WIDTH-1:WIDTH];
            SRC_ZLO: bus = z[WIDTH-1:0];
            SRC_PC:  bus = pc;
            SRC_MDR: bus = mdr;
            default: bus = '0;
        endcase
    end

    always_comb begin
        alu_c = '0;
        op    = OP_PASS;
        if (ctrl.AND) begin
            alu_c[WIDTH-1:0] = y & bus;
            op               = OP_AND;
        end
`ifdef ALU_ADD_EN
        else if (ctrl.ADD) begin
            alu_c[WIDTH-1:0] = y + bus;
            op               = OP_ADD;
        end
`endif
        else if (ctrl.IncPC) begin
            alu_c[WIDTH-1:0] = bus + WIDTH'(1);
            op               = OP_INC;
        end else begin
            alu_c[WIDTH-1:0] = bus;
            op               = OP_PASS;
        end
    end

    assign ctrl.operation = op;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r3  <= '0;
            r4  <= '0;
            r7  <= '0;
            pc  <= '0;
            ir  <= '0;
            mar <= '0;
            mdr <= '0;
            y   <= '0;
            z   <= '0;
        end else begin
            if (ctrl.R3in)  r3  <= bus;
            if (ctrl.R4in)  r4  <= bus;
            if (ctrl.R7in)  r7  <= bus;
            if (ctrl.PCin)  pc  <= bus;
            if (ctrl.IRin)  ir  <= bus;
            if (ctrl.MARin) mar <= bus;
            if (ctrl.Yin)   y   <= bus;
            if (ctrl.Zin)   z   <= alu_c;
            if (ctrl.MDRin) mdr <= ctrl.Read ? ctrl.Mdatain : bus;
        end
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed-vector bench for cpu_datapath with hand-computed expectations.
// Internal registers are observed hierarchically; ALU_ADD_EN adds an ADD step.
module tb_cpu_datapath;

    logic Clock;
    logic Resetn;
    int   checks;
    int   errors;

    cpu_datapath_if ifc();

    cpu_datapath #(.WIDTH(32)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .ctrl   (ifc)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ifc.PCout = 0; ifc.Zlowout = 0; ifc.MDRout = 0; ifc.R3out = 0; ifc.R7out = 0;
        ifc.MARin = 0; ifc.Zin = 0; ifc.PCin = 0; ifc.MDRin = 0; ifc.IRin = 0;
        ifc.Yin = 0; ifc.R3in = 0; ifc.R4in = 0; ifc.R7in = 0;
        ifc.IncPC = 0; ifc.AND = 0; ifc.Read = 0;
        ifc.encoder_input = 32'h0;
`ifdef ALU_ADD_EN
        ifc.ADD = 0;
`endif
    endtask

    task automatic cycle();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        ifc.Mdatain = 32'hFFFF_FFFF;

        // Reset with every load enable high and all-ones memory data.
        Resetn = 0;
        ifc.MARin = 1; ifc.Zin = 1; ifc.PCin = 1; ifc.MDRin = 1; ifc.IRin = 1;
        ifc.Yin = 1; ifc.R3in = 1; ifc.R4in = 1; ifc.R7in = 1; ifc.Read = 1;
        cycle();
        Resetn = 1;
        idle();
        #1;
        chk("rst_r3", 64'(dut.r3), 64'h0);
        chk("rst_r4", 64'(dut.r4), 64'h0);
        chk("rst_r7", 64'(dut.r7), 64'h0);
        chk("rst_pc", 64'(dut.pc), 64'h0);
        chk("rst_ir", 64'(dut.ir), 64'h0);
        chk("rst_mar", 64'(dut.mar), 64'h0);
        chk("rst_mdr", 64'(dut.mdr), 64'h0);
        chk("rst_y", 64'(dut.y), 64'h0);
        chk("rst_z", dut.z, 64'h0);
        chk("rst_bus", 64'(dut.bus), 64'h0);
        chk("rst_op", 64'(ifc.operation), 64'h0);

        // Load path: memory -> MDR -> R3 / R7 / R4
        ifc.Mdatain = 32'h22; ifc.Read = 1; ifc.MDRin = 1;
        cycle(); idle();
        chk("mdr_22", 64'(dut.mdr), 64'h22);
        ifc.MDRout = 1; ifc.R3in = 1; #1;
        chk("bus_22", 64'(dut.bus), 64'h22);
        cycle(); idle();
        chk("r3_22", 64'(dut.r3), 64'h22);

        ifc.Mdatain = 32'h24; ifc.Read = 1; ifc.MDRin = 1;
        cycle(); idle();
        ifc.encoder_input = 32'h0020_0000; ifc.R7in = 1; #1;
        chk("bus_24_enc", 64'(dut.bus), 64'h24);
        cycle(); idle();
        chk("r7_24", 64'(dut.r7), 64'h24);

        ifc.Mdatain = 32'h28; ifc.Read = 1; ifc.MDRin = 1;
        cycle(); idle();
        ifc.MDRout = 1; ifc.R4in = 1;
        cycle(); idle();
        chk("r4_28", 64'(dut.r4), 64'h28);

        // AND: R4 <= R3 & R7
        ifc.R3out = 1; ifc.Yin = 1;
        cycle(); idle();
        chk("y_22", 64'(dut.y), 64'h22);
        ifc.R7out = 1; ifc.AND = 1; ifc.Zin = 1; #1;
        chk("op_and", 64'(ifc.operation), 64'b00101);
        cycle(); idle();
        chk("z_and", dut.z, 64'h20);
        ifc.Zlowout = 1; ifc.R4in = 1;
        cycle(); idle();
        chk("r4_and", 64'(dut.r4), 64'h20);

        // Fetch
        ifc.PCout = 1; ifc.MARin = 1; ifc.IncPC = 1; ifc.Zin = 1; #1;
        chk("op_inc", 64'(ifc.operation), 64'b11001);
        cycle(); idle();
        chk("mar_0", 64'(dut.mar), 64'h0);
        chk("z_inc", dut.z, 64'h1);
        ifc.Zlowout = 1; ifc.PCin = 1; ifc.Read = 1; ifc.MDRin = 1;
        ifc.Mdatain = 32'h2A2B_8000;
        cycle(); idle();
        chk("pc_1", 64'(dut.pc), 64'h1);
        chk("mdr_instr", 64'(dut.mdr), 64'h2A2B_8000);
        ifc.MDRout = 1; ifc.IRin = 1;
        cycle(); idle();
        chk("ir_instr", 64'(dut.ir), 64'h2A2B_8000);

        // Encoder priority
        ifc.encoder_input = 32'h0020_0000; ifc.PCout = 1; #1;
        chk("prio_mdr_over_pc", 64'(dut.bus), 64'h2A2B_8000);
        idle(); ifc.R3out = 1; ifc.R7out = 1; #1;
        chk("prio_r7_over_r3", 64'(dut.bus), 64'h24);
        idle(); ifc.encoder_input = 32'h0040_0000; ifc.PCout = 1; #1;
        chk("prio_inport_zero", 64'(dut.bus), 64'h0);
        idle(); #1;
        chk("bus_empty", 64'(dut.bus), 64'h0);
        chk("op_pass_idle", 64'(ifc.operation), 64'h0);

        // Increment wrap
        ifc.Mdatain = 32'hFFFF_FFFF; ifc.Read = 1; ifc.MDRin = 1;
        cycle(); idle();
        ifc.MDRout = 1; ifc.PCin = 1;
        cycle(); idle();
        chk("pc_max", 64'(dut.pc), 64'hFFFF_FFFF);
        ifc.PCout = 1; ifc.IncPC = 1; ifc.Zin = 1;
        cycle(); idle();
        chk("z_wrap", dut.z, 64'h0);
        ifc.Zlowout = 1; ifc.PCin = 1;
        cycle(); idle();
        chk("pc_wrap", 64'(dut.pc), 64'h0);

        // Self reload and multi-destination load
        ifc.R3out = 1; ifc.R3in = 1;
        cycle(); idle();
        chk("r3_self", 64'(dut.r3), 64'h22);
        ifc.R7out = 1; ifc.R3in = 1; ifc.Yin = 1;
        cycle(); idle();
        chk("multi_r3", 64'(dut.r3), 64'h24);
        chk("multi_y", 64'(dut.y), 64'h24);

        // Pass-through into Z, then read back via Zhigh request
        ifc.R7out = 1; ifc.Zin = 1;
        cycle(); idle();
        chk("z_pass", dut.z, 64'h24);
        ifc.encoder_input = 32'h0004_0000; #1;
        chk("bus_zhigh", 64'(dut.bus), 64'h0);
        idle();

`ifdef ALU_ADD_EN
        ifc.R3out = 1; ifc.ADD = 1; ifc.AND = 0; ifc.Zin = 1; #1;
        chk("op_add", 64'(ifc.operation), 64'b00011);
        cycle(); idle();
        chk("z_add", dut.z, 64'h48);
        ifc.R3out = 1; ifc.ADD = 1; ifc.AND = 1; #1;
        chk("op_and_over_add", 64'(ifc.operation), 64'b00101);
        idle();
`endif

        // Reset overrides a pending load
        Resetn = 0; ifc.R7out = 1; ifc.R3in = 1;
        cycle(); idle(); Resetn = 1;
        chk("rst_prio_r3", 64'(dut.r3), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- 32-bit bus-based datapath slice of the simple CPU: general registers R3/R4/R7, plus PC, IR, MAR, MDR, Y and a 64-bit Z result register.
- A single shared bus is sourced through a 32-to-5 priority encoder and a bus multiplexer. A small ALU feeds Z.
- An external control unit or testbench drives all register-enable and bus-out strobes, one micro-step per clock.

Parameters:
- WIDTH, 32, data/bus width. Fixed at 32; other values are unsupported.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Resetn  in  1  synchronous, active-low reset.
- PCout, Zlowout, MDRout, R3out, R7out  in  1 each  bus-source strobes.
- MARin, Zin, PCin, MDRin, IRin, Yin, R3in, R4in, R7in  in  1 each  register load enables.
- IncPC  in  1  ALU increment request.
- AND  in  1  ALU bitwise-AND request.
- Read  in  1  MDR input select: 1 = Mdatain, 0 = bus.
- Mdatain  in  32  memory read data.
- encoder_input  in  32  extra one-hot bus-source request vector, ORed with the strobes.
- operation  out  5  ALU operation code currently selected.

Behaviour:
- Reset: if Resetn=0 at a rising Clock edge, R3, R4, R7, PC, IR, MAR, MDR, Y and Z (64 bits) all clear to 0. Reset has priority over every load enable.
- Bus source request vector = encoder_input OR the strobe bits.
- Strobe bit map: R0..R15 = bits 0..15 (only R3 and R7 have strobes), HI = 16, LO = 17, Zhigh = 18, Zlow = 19, PC = 20, MDR = 21, InPort = 22, C = 23.
- Encoder is priority-based: the highest set bit wins.
- Bus is combinational from the encoded select:
  - Valid sources: R3, R7, PC, MDR, Z[31:0], Z[63:32].
  - Unimplemented sources (other registers, HI, LO, InPort, C) drive 0.
  - An empty request vector drives 0.
- Register loads: each register loads the bus on the rising edge when its *in strobe is 1; otherwise it holds.
  - R4 has no out strobe; R3 and R7 load and drive the bus.
  - MAR and IR are internal; IR is captured for the control unit only.
- MDR: when MDRin=1, MDR loads Mdatain if Read=1, else the bus.
- ALU (combinational; operands are Y and the bus). Priority AND > IncPC > pass:
  - AND=1: C = {32'b0, Y & bus}; operation = 5'b00101.
  - IncPC=1: C = {32'b0, bus + 1}, wrapping modulo 2^32 (0xFFFFFFFF+1 = 0); operation = 5'b11001.
  - Neither: C = {32'b0, bus}; operation = 5'b00000.
- Z loads C on the rising edge when Zin=1.
- Latency: a register-to-register transfer completes in 1 cycle. A full ALU operation takes 3 cycles: Yin, then Zin, then Zlowout plus destination in.
- Simultaneous events:
  - A register with both out and in strobes asserted re-loads its own value.
  - When several registers load in the same cycle, all of them capture the same bus value.

Optional Feature:
- Macro: ALU_ADD_EN.
- Defined:
  - Adds input port ADD (1 bit).
  - ADD=1 gives C = {32'b0, Y + bus} (mod 2^32) and operation = 5'b00011.
  - Priority becomes AND > ADD > IncPC.
- Undefined: no ADD port and no add path; behaviour is otherwise identical.

Test Plan:
- Resetn=0 for one edge with all in strobes high and Mdatain=0xFFFFFFFF -> every register reads 0 and bus=0.
- Load path: Mdatain=0x22, Read=1, MDRin=1 for one edge; then MDRout=1 (or encoder_input=0x00200000) with R3in=1 -> MDR=0x22, R3=0x22, bus=0x22 during the transfer. Repeat with 0x24 -> R7 and 0x28 -> R4.
- AND sequence with R3=0x22, R7=0x24:
  - R3out+Yin -> Y=0x22.
  - R7out+AND+Zin -> operation=00101, Z[31:0]=0x20.
  - Zlowout+R4in -> R4=0x20.
- Fetch:
  - PC=0: PCout+MARin+IncPC+Zin -> MAR=0, Z=1.
  - Zlowout+PCin+Read+MDRin with Mdatain=0x2A2B8000 -> PC=1, MDR=0x2A2B8000.
  - MDRout+IRin -> IR=0x2A2B8000.
- Encoder priority: encoder_input=0x00200000 together with PCout=1 -> MDR (bit 21) drives the bus. encoder_input=0 with no strobes -> bus=0.
- Wrap: PC=0xFFFFFFFF, PCout+IncPC+Zin, then Zlowout+PCin -> PC=0.
